// File: rtl/freq_div.sv
// Programmable integer clock divider.
// With the divider enabled and a latched ratio N >= 2, clk_out runs at clk_ref/N
// with a low phase of ceil(N/2) cycles followed by a high phase of floor(N/2)
// cycles. A new ratio is taken only at the high-to-low boundary, so changing
// div_ratio while dividing never produces a runt pulse. With the divider
// disabled, or a latched ratio of 0 or 1, clk_out is clk_ref passed straight
// through.
// The reset input is active-high and synchronous despite its name.
module freq_div #(
   parameter int WIDTH = 3
) (
   input  logic             clk_ref,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic [WIDTH-1:0] div_ratio,
   output logic             clk_out
);

   localparam logic [WIDTH:0]   EXT_ONE = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Registered state
   logic [WIDTH-1:0] cnt;
   logic             div_clk;
   logic [WIDTH-1:0] ratio_q;

   // Next-state values
   logic [WIDTH-1:0] cnt_next;
   logic             div_clk_next;
   logic [WIDTH-1:0] ratio_next;

   // Phase lengths are computed one bit wider than the ratio so that
   // ceil(N/2) cannot wrap for the largest ratio.
   logic [WIDTH:0] ratio_ext;
   logic [WIDTH:0] cnt_ext;
   logic [WIDTH:0] low_last;
   logic [WIDTH:0] high_last;
   logic           ratio_small;
   logic           bypass;

   assign ratio_ext   = {1'b0, ratio_q};
   assign cnt_ext     = {1'b0, cnt};
   // Last count of the low phase: ceil(N/2) - 1
   assign low_last    = ((ratio_ext + EXT_ONE) >> 1) - EXT_ONE;
   // Last count of the high phase: floor(N/2) - 1
   assign high_last   = (ratio_ext >> 1) - EXT_ONE;
   // Ratios 0 and 1 have every bit above bit 0 clear
   assign ratio_small = (ratio_q[WIDTH-1:1] == '0);
   assign bypass      = ~clk_en | ratio_small;

   // The mux is combinational on purpose: dropping clk_en hands the output
   // back to clk_ref at once, and the possible glitch at that moment is accepted.
   assign clk_out = bypass ? clk_ref : div_clk;

   // State register; reset has priority over everything else
   always_ff @(posedge clk_ref) begin
      if (rst_n) begin
         cnt     <= '0;
         div_clk <= 1'b0;
         ratio_q <= div_ratio;
      end else begin
         cnt     <= cnt_next;
         div_clk <= div_clk_next;
         ratio_q <= ratio_next;
      end
   end

   // Next-state: clear while bypassed, otherwise walk the low/high phases
   always_comb begin
      cnt_next     = cnt + CNT_ONE;
      div_clk_next = div_clk;
      ratio_next   = ratio_q;
      if (bypass) begin
         // Keep tracking the requested ratio so division can start as soon
         // as it is enabled with a ratio of 2 or more.
         cnt_next     = '0;
         div_clk_next = 1'b0;
         ratio_next   = div_ratio;
      end else if (!div_clk && (cnt_ext == low_last)) begin
         cnt_next     = '0;
         div_clk_next = 1'b1;
      end else if (div_clk && (cnt_ext == high_last)) begin
         // End of period: the only point where a new ratio is adopted
         cnt_next     = '0;
         div_clk_next = 1'b0;
         ratio_next   = div_ratio;
      end
   end

endmodule

// File: tb/tb_freq_div.sv
// Bench for freq_div: table-driven runs plus hand-written corner sequences.
// The driver pushes the expected clk_out for the coming clock edge into a
// scoreboard queue; a monitor pops it and checks clk_out just after the rising
// edge and just after the following falling edge.
module tb_freq_div;

   localparam int WIDTH = 3;

   logic             clk_ref = 1'b0;
   logic             rst_n   = 1'b0;
   logic             clk_en  = 1'b0;
   logic [WIDTH-1:0] div_ratio = '0;
   logic             clk_out;

   freq_div #(.WIDTH(WIDTH)) dut (
      .clk_ref  (clk_ref),
      .rst_n    (rst_n),
      .clk_en   (clk_en),
      .div_ratio(div_ratio),
      .clk_out  (clk_out)
   );

   always #5 clk_ref = ~clk_ref;

   typedef struct {
      logic  chk;
      logic  hi;
      logic  lo;
      string tag;
   } exp_t;

   typedef struct {
      logic  en;
      int    ratio;
      int    cycles;
      string tag;
   } vec_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Expected divided output after the k-th enabled edge (k = 0 is the first):
   // low for ceil(N/2) cycles then high for floor(N/2), first rise at k = L-1.
   function automatic logic model_div(input int n, input int k);
      int l;
      int h;
      int p;
      l = (n + 1) / 2;
      h = n / 2;
      p = k - (l - 1);
      if (p < 0) return 1'b0;
      return ((p % n) < h) ? 1'b1 : 1'b0;
   endfunction

   task automatic compare(input string tag, input string phase, input logic act, input logic want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s (%s): clk_out=%b expected=%b at %0t", tag, phase, act, want, $time);
      end
   endtask

   // Drive one cycle's inputs mid low phase and queue the expectation
   task automatic step(input logic rst, input logic en, input int ratio,
                       input logic chk, input logic hi, input logic lo, input string tag);
      exp_t e;
      @(negedge clk_ref);
      #2;
      rst_n     = rst;
      clk_en    = en;
      div_ratio = WIDTH'(ratio);
      e.chk = chk;
      e.hi  = hi;
      e.lo  = lo;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Reset with the given inputs; after the reset edge the output is clk_ref
   // when bypassing and 0 otherwise.
   task automatic do_reset(input logic en, input int ratio, input string tag);
      logic byp;
      byp = !en || (ratio < 2);
      step(1'b1, en, ratio, 1'b1, byp, 1'b0, {tag, "_rst"});
   endtask

   // Run enabled/bypass cycles from the k0-th edge onward with fixed inputs
   task automatic run_cycles(input logic en, input int ratio, input int k0,
                             input int count, input string tag);
      logic byp;
      logic d;
      byp = !en || (ratio < 2);
      for (int k = k0; k < k0 + count; k++) begin
         d = model_div(ratio, k);
         if (byp) step(1'b0, en, ratio, 1'b1, 1'b1, 1'b0, tag);
         else     step(1'b0, en, ratio, 1'b1, d, d, tag);
      end
   endtask

   vec_t vecs[8];
   logic [0:13] pat_change;

   initial begin
      vecs[0] = '{en: 1'b0, ratio: 6, cycles: 12, tag: "bypass_en0_r6"};
      vecs[1] = '{en: 1'b1, ratio: 6, cycles: 20, tag: "div6"};
      vecs[2] = '{en: 1'b1, ratio: 5, cycles: 20, tag: "div5"};
      vecs[3] = '{en: 1'b1, ratio: 1, cycles: 8,  tag: "pass_r1"};
      vecs[4] = '{en: 1'b1, ratio: 0, cycles: 8,  tag: "pass_r0"};
      vecs[5] = '{en: 1'b1, ratio: 2, cycles: 8,  tag: "div2"};
      vecs[6] = '{en: 1'b1, ratio: 7, cycles: 21, tag: "div7"};
      vecs[7] = '{en: 1'b1, ratio: 3, cycles: 9,  tag: "div3"};
      // Divide by 6 switching to 4 during the first high phase
      pat_change = 14'b00111001100110;

      // Monitor: pop one expectation per rising edge, check both clock halves
      fork
         forever begin
            exp_t e;
            @(posedge clk_ref);
            #1;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               if (e.chk) compare(e.tag, "after rise", clk_out, e.hi);
               @(negedge clk_ref);
               #1;
               if (e.chk) begin
                  compare(e.tag, "after fall", clk_out, e.lo);
                  $display("txn %-16s clk_out hi=%b lo=%b t=%0t", e.tag, e.hi, e.lo, $time);
               end
            end
         end
      join_none

      // Table-driven runs, each from a fresh reset
      for (int i = 0; i < 8; i++) begin
         do_reset(vecs[i].en, vecs[i].ratio, vecs[i].tag);
         run_cycles(vecs[i].en, vecs[i].ratio, 0, vecs[i].cycles, vecs[i].tag);
      end

      // Pass-through ratio 1 then 0 without a reset in between
      do_reset(1'b1, 1, "pass_1_0");
      run_cycles(1'b1, 1, 0, 4, "pass_1_0_r1");
      run_cycles(1'b1, 0, 0, 4, "pass_1_0_r0");

      // Ratio change 6 -> 4 mid high phase: 6-cycle period completes, then 4
      do_reset(1'b1, 6, "ratio_chg");
      for (int k = 0; k < 14; k++) begin
         step(1'b0, 1'b1, (k < 3) ? 6 : 4, 1'b1, pat_change[k], pat_change[k], "ratio_chg");
      end

      // Reset asserted mid high phase, held two cycles, then clean restart
      do_reset(1'b1, 6, "mid_rst");
      run_cycles(1'b1, 6, 0, 4, "mid_rst_pre");
      step(1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0, "mid_rst_hold");
      step(1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0, "mid_rst_hold");
      run_cycles(1'b1, 6, 0, 8, "mid_rst_post");

      // Enable dropped mid high phase: immediate bypass, then clean restart
      do_reset(1'b1, 6, "en_drop");
      run_cycles(1'b1, 6, 0, 4, "en_drop_pre");
      run_cycles(1'b0, 6, 0, 2, "en_drop_off");
      run_cycles(1'b1, 6, 0, 8, "en_drop_post");

      // Let the last expectations drain, bounded
      repeat (3) @(negedge clk_ref);
      #4;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
